rr_requester: RTL and testbench
===============================

RR_REQUESTER -- requirements
Module: rr_requester

Interface
REQ-001 Parameter: CNT_W, default 4, width of each client's pending-job counter (max 2^CNT_W-1 jobs).
REQ-002 Parameter: BEATS, default 2, granted cycles needed to complete one job (>=1).
REQ-003 Parameter: STARVE_LIMIT, default 8, consecutive requested-but-ungranted cycles that flag starvation.
REQ-004 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-006 Port: push  input  4  push[i]=1 enqueues one job for client i in that cycle.
REQ-007 Port: gnt  input  4  grant from the round-robin arbiter, one-hot expected, 0000 = idle.
REQ-008 Port: clr_err  input  1  single-cycle pulse that clears all sticky error and starvation flags.
REQ-009 Port: req  output  4  request vector to the arbiter, one bit per client.
REQ-010 Port: done  output  4  registered one-cycle pulse per client on job completion.
REQ-011 Port: overflow  output  4  sticky per-client flag: a push was dropped.
REQ-012 Port: starve  output  4  sticky per-client starvation flag.
REQ-013 Port: err_multi  output  1  sticky flag: gnt had more than one bit set.
REQ-014 Port: err_spur  output  1  sticky flag: gnt bit set for a client with req low.

Function
REQ-015 Per client i, pending[i] (CNT_W bits) holds queued jobs; req[i] is pending[i]!=0, decoded from registered state, no combinational path from push or gnt.
REQ-016 Push at edge t -> pending increments at t+1 -> req[i] high in cycle t+1.
REQ-017 Valid beat for client i: gnt[i]=1 and req[i]=1 in the same cycle, and gnt is one-hot.
REQ-018 Per client beat[i] counts valid beats 0..BEATS-1; beats need not be consecutive; beat[i] holds while gnt[i]=0.
REQ-019 Valid beat with beat[i]=BEATS-1: beat[i] to 0, pending[i] decrements, done[i] pulses high in the next cycle for exactly one cycle.
REQ-020 Push and job completion on the same client in the same cycle: pending unchanged, push accepted even when pending is at maximum.
REQ-021 Push with pending at maximum and no completion that cycle: push dropped, pending unchanged, overflow[i] set.
REQ-022 gnt with more than one bit set: err_multi set; no beat counted for any client that cycle.
REQ-023 gnt[i]=1 with req[i]=0: err_spur set; no state change for client i.
REQ-024 Per client wait[i] increments each cycle with req[i]=1 and gnt[i]=0, saturating at STARVE_LIMIT; clears when gnt[i]=1 or req[i]=0.
REQ-025 wait[i] reaching STARVE_LIMIT sets starve[i] in the same update.
REQ-026 clr_err=1 clears overflow, starve, err_multi, err_spur at the next edge; an error event in the same cycle takes priority, so its flag is set.
REQ-027 Clients are independent; simultaneous events on different clients are all processed in the same cycle.

Reset
REQ-028 rst_n low asynchronously clears pending, beat, wait, done, overflow, starve, err_multi, err_spur to 0, so req=0000 and done=0000 immediately.
REQ-029 Reset mid-job discards all queued and partial jobs; no done pulse is emitted for them after release.
REQ-030 First state update occurs on the first rising clk edge with rst_n high.

Verification
REQ-031 Single job: push=0001 one cycle, gnt=0001 for 2 cycles starting when req[0]=1 -> req=0001 one cycle after push; done=0001 one cycle after the 2nd beat; req returns to 0000.
REQ-032 Interleaved beats: jobs on clients 0 and 1, gnt alternating 0001/0010 -> both done pulses after each client's 2nd beat; beat counters unaffected by the other client's grants.
REQ-033 Overflow: 16 pushes to client 2 with CNT_W=4, no grants -> pending=15, overflow=0100; a push on the completing cycle of a job at pending=15 -> no overflow, pending stays 15.
REQ-034 Protocol errors: gnt=0011 with both requesting -> err_multi=1, no beats counted; gnt=1000 with req[3]=0 -> err_spur=1; clr_err pulse -> both 0.
REQ-035 Starvation: client 3 requesting, gnt=0000 for 8 cycles -> starve=1000 after the 8th cycle; holds until clr_err.
REQ-036 Reset mid-job: after 1 of 2 beats, pulse rst_n low -> req=0000 immediately; after release, no done pulse occurs and all flags read 0.

Source files
------------

// File: rtl/rr_requester.sv
// rr_requester: per-client job queue front end for a round-robin arbiter.
// Each of the four clients keeps a pending-job counter and raises req while
// jobs are queued. A job completes after BEATS valid grant beats, which need
// not be consecutive. Protocol errors on gnt, dropped pushes and starvation
// are reported through sticky flags that clr_err clears.
module rr_requester #(
    parameter int CNT_W        = 4,
    parameter int BEATS        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] push,
    input  logic [3:0] gnt,
    input  logic       clr_err,
    output logic [3:0] req,
    output logic [3:0] done,
    output logic [3:0] overflow,
    output logic [3:0] starve,
    output logic       err_multi,
    output logic       err_spur
);

    localparam int N      = 4;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0]  PEND_MAX  = {CNT_W{1'b1}};
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(STARVE_LIMIT);

    // Registered state
    logic [N-1:0][CNT_W-1:0]  r_pending;
    logic [N-1:0][BEAT_W-1:0] r_beat;
    logic [N-1:0][WAIT_W-1:0] r_wait;
    logic [N-1:0]             r_done;
    logic [N-1:0]             r_overflow;
    logic [N-1:0]             r_starve;
    logic                     r_err_multi;
    logic                     r_err_spur;

    // Next-state and event wires
    logic [N-1:0]             w_req;
    logic                     w_multi;
    logic [N-1:0]             w_valid;
    logic [N-1:0]             w_fin;
    logic [N-1:0][CNT_W-1:0]  w_pending_nxt;
    logic [N-1:0][BEAT_W-1:0] w_beat_nxt;
    logic [N-1:0][WAIT_W-1:0] w_wait_nxt;
    logic [N-1:0]             w_ovf_ev;
    logic [N-1:0]             w_starve_ev;
    logic [N-1:0]             w_spur_ev;
    logic [N-1:0]             w_overflow_nxt;
    logic [N-1:0]             w_starve_nxt;
    logic                     w_err_multi_nxt;
    logic                     w_err_spur_nxt;

    // Request decode: purely from registered counters, never from push or gnt.
    always_comb begin
        w_req = '0;
        for (int i = 0; i < N; i++) begin
            w_req[i] = (r_pending[i] != '0);
        end
    end

    // Per-client beat, pending, wait and error-event computation.
    always_comb begin
        // A grant with more than one bit set counts no beats anywhere.
        w_multi        = ((gnt & (gnt - 4'd1)) != 4'd0);
        w_valid        = '0;
        w_fin          = '0;
        w_pending_nxt  = r_pending;
        w_beat_nxt     = r_beat;
        w_wait_nxt     = '0;
        w_ovf_ev       = '0;
        w_starve_ev    = '0;
        w_spur_ev      = '0;
        for (int i = 0; i < N; i++) begin
            w_valid[i]   = gnt[i] & w_req[i] & ~w_multi;
            w_fin[i]     = w_valid[i] & (r_beat[i] == BEAT_LAST);
            w_spur_ev[i] = gnt[i] & ~w_req[i];

            if (w_fin[i]) begin
                w_beat_nxt[i] = '0;
            end else if (w_valid[i]) begin
                w_beat_nxt[i] = r_beat[i] + BEAT_W'(1);
            end else begin
                w_beat_nxt[i] = r_beat[i];
            end

            // A push on a completing cycle takes the freed slot, even when full.
            if (push[i] && !w_fin[i]) begin
                if (r_pending[i] == PEND_MAX) begin
                    w_pending_nxt[i] = r_pending[i];
                    w_ovf_ev[i]      = 1'b1;
                end else begin
                    w_pending_nxt[i] = r_pending[i] + CNT_W'(1);
                end
            end else if (w_fin[i] && !push[i]) begin
                w_pending_nxt[i] = r_pending[i] - CNT_W'(1);
            end else begin
                w_pending_nxt[i] = r_pending[i];
            end

            if (w_req[i] && !gnt[i]) begin
                if (r_wait[i] == WAIT_MAX) begin
                    w_wait_nxt[i] = r_wait[i];
                end else begin
                    w_wait_nxt[i] = r_wait[i] + WAIT_W'(1);
                end
            end else begin
                w_wait_nxt[i] = '0;
            end

            // Starvation is flagged on the transition into the limit.
            w_starve_ev[i] = (w_wait_nxt[i] == WAIT_MAX) && (r_wait[i] != WAIT_MAX);
        end
    end

    // Sticky flag update: a new event wins over a simultaneous clear.
    always_comb begin
        w_overflow_nxt  = (r_overflow & {N{~clr_err}}) | w_ovf_ev;
        w_starve_nxt    = (r_starve & {N{~clr_err}}) | w_starve_ev;
        w_err_multi_nxt = (r_err_multi & ~clr_err) | w_multi;
        w_err_spur_nxt  = (r_err_spur & ~clr_err) | (|w_spur_ev);
    end

    // State register with asynchronous clear of all queued work and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending   <= '0;
            r_beat      <= '0;
            r_wait      <= '0;
            r_done      <= '0;
            r_overflow  <= '0;
            r_starve    <= '0;
            r_err_multi <= 1'b0;
            r_err_spur  <= 1'b0;
        end else begin
            r_pending   <= w_pending_nxt;
            r_beat      <= w_beat_nxt;
            r_wait      <= w_wait_nxt;
            r_done      <= w_fin;
            r_overflow  <= w_overflow_nxt;
            r_starve    <= w_starve_nxt;
            r_err_multi <= w_err_multi_nxt;
            r_err_spur  <= w_err_spur_nxt;
        end
    end

    assign req       = w_req;
    assign done      = r_done;
    assign overflow  = r_overflow;
    assign starve    = r_starve;
    assign err_multi = r_err_multi;
    assign err_spur  = r_err_spur;

endmodule

// File: tb/tb_rr_requester.sv
// Bench for rr_requester: directed scenarios followed by random traffic, with
// every cycle compared against a job-level reference model.
module tb_rr_requester;

    localparam int CNT_W        = 4;
    localparam int BEATS        = 2;
    localparam int STARVE_LIMIT = 8;
    localparam int PEND_MAX     = (1 << CNT_W) - 1;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic [3:0] push    = 4'b0000;
    logic [3:0] gnt     = 4'b0000;
    logic       clr_err = 1'b0;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] overflow;
    logic [3:0] starve;
    logic       err_multi;
    logic       err_spur;

    int checks   = 0;
    int failures = 0;

    // Reference model: job counts, beats served, cycles waited, flags.
    int         m_pend[4];
    int         m_beat[4];
    int         m_wait[4];
    logic [3:0] m_done;
    logic [3:0] m_ovf;
    logic [3:0] m_starve;
    logic       m_multi;
    logic       m_spur;

    rr_requester #(
        .CNT_W(CNT_W),
        .BEATS(BEATS),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .gnt(gnt),
        .clr_err(clr_err),
        .req(req),
        .done(done),
        .overflow(overflow),
        .starve(starve),
        .err_multi(err_multi),
        .err_spur(err_spur)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_req();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (m_pend[i] > 0);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 0;
            m_beat[i] = 0;
            m_wait[i] = 0;
        end
        m_done   = 4'b0000;
        m_ovf    = 4'b0000;
        m_starve = 4'b0000;
        m_multi  = 1'b0;
        m_spur   = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] p, input logic [3:0] g, input logic c);
        int         nset;
        logic [3:0] ev_ovf;
        logic [3:0] ev_starve;
        logic       ev_spur;
        nset      = $countones(g);
        ev_ovf    = 4'b0000;
        ev_starve = 4'b0000;
        ev_spur   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit rq;
            bit fin;
            int nw;
            rq  = (m_pend[i] > 0);
            fin = 1'b0;
            if (g[i] && !rq) ev_spur = 1'b1;
            if (g[i] && rq && nset == 1) begin
                if (m_beat[i] == BEATS - 1) begin
                    fin       = 1'b1;
                    m_beat[i] = 0;
                end else begin
                    m_beat[i] = m_beat[i] + 1;
                end
            end
            m_done[i] = fin;
            if (p[i] && !fin) begin
                if (m_pend[i] == PEND_MAX) ev_ovf[i] = 1'b1;
                else m_pend[i] = m_pend[i] + 1;
            end else if (fin && !p[i]) begin
                m_pend[i] = m_pend[i] - 1;
            end
            if (rq && !g[i]) nw = (m_wait[i] < STARVE_LIMIT) ? m_wait[i] + 1 : STARVE_LIMIT;
            else nw = 0;
            if (nw == STARVE_LIMIT && m_wait[i] != STARVE_LIMIT) ev_starve[i] = 1'b1;
            m_wait[i] = nw;
        end
        if (c) begin
            m_ovf    = ev_ovf;
            m_starve = ev_starve;
            m_multi  = (nset > 1);
            m_spur   = ev_spur;
        end else begin
            m_ovf    = m_ovf | ev_ovf;
            m_starve = m_starve | ev_starve;
            m_multi  = m_multi | (nset > 1);
            m_spur   = m_spur | ev_spur;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".req"},       req,       model_req());
        check({tag, ".done"},      done,      m_done);
        check({tag, ".overflow"},  overflow,  m_ovf);
        check({tag, ".starve"},    starve,    m_starve);
        check({tag, ".err_multi"}, err_multi, m_multi);
        check({tag, ".err_spur"},  err_spur,  m_spur);
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, compare.
    task automatic step(input string tag, input logic [3:0] p, input logic [3:0] g, input logic c);
        push    = p;
        gnt     = g;
        clr_err = c;
        @(posedge clk);
        model_step(p, g, c);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse taken between clock edges.
    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        check({tag, ".req_now"}, req, 4'b0000);
        @(negedge clk);
        push    = 4'b0000;
        gnt     = 4'b0000;
        clr_err = 1'b0;
        rst_n   = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        check_all("reset");
        check("reset.req_const", req, 4'b0000);
        #10;
        rst_n = 1'b1;
        step("post_reset", 4'b0000, 4'b0000, 1'b0);

        // Single job on client 0
        step("single.push", 4'b0001, 4'b0000, 1'b0);
        check("single.req_up", req, 4'b0001);
        step("single.beat0", 4'b0000, 4'b0001, 1'b0);
        check("single.no_done_yet", done, 4'b0000);
        step("single.beat1", 4'b0000, 4'b0001, 1'b0);
        check("single.done", done, 4'b0001);
        check("single.req_down", req, 4'b0000);
        step("single.idle", 4'b0000, 4'b0000, 1'b0);
        check("single.done_one_cycle", done, 4'b0000);

        // Interleaved beats on clients 0 and 1
        step("inter.push", 4'b0011, 4'b0000, 1'b0);
        step("inter.g0a", 4'b0000, 4'b0001, 1'b0);
        step("inter.g1a", 4'b0000, 4'b0010, 1'b0);
        check("inter.no_done", done, 4'b0000);
        step("inter.g0b", 4'b0000, 4'b0001, 1'b0);
        check("inter.done0", done, 4'b0001);
        step("inter.g1b", 4'b0000, 4'b0010, 1'b0);
        check("inter.done1", done, 4'b0010);
        step("inter.idle", 4'b0000, 4'b0000, 1'b0);

        // Overflow on client 2
        for (int k = 0; k < 16; k++) step("ovf.push", 4'b0100, 4'b0000, 1'b0);
        check("ovf.flag", overflow, 4'b0100);
        step("ovf.clr", 4'b0000, 4'b0000, 1'b1);
        check("ovf.cleared", overflow, 4'b0000);
        step("ovf.beat0", 4'b0000, 4'b0100, 1'b0);
        step("ovf.fin_push", 4'b0100, 4'b0100, 1'b0);
        check("ovf.fin_push_done", done, 4'b0100);
        check("ovf.fin_push_noovf", overflow, 4'b0000);
        for (int k = 0; k < 40 && m_pend[2] > 0; k++) step("ovf.drain", 4'b0000, 4'b0100, 1'b0);
        check("ovf.drained", req, 4'b0000);
        step("ovf.clr2", 4'b0000, 4'b0000, 1'b1);

        // Protocol errors
        step("proto.push", 4'b0011, 4'b0000, 1'b0);
        step("proto.multi", 4'b0000, 4'b0011, 1'b0);
        check("proto.err_multi", err_multi, 1'b1);
        step("proto.spur", 4'b0000, 4'b1000, 1'b0);
        check("proto.err_spur", err_spur, 1'b1);
        step("proto.clr", 4'b0000, 4'b0000, 1'b1);
        check("proto.clr_multi", err_multi, 1'b0);
        check("proto.clr_spur", err_spur, 1'b0);
        step("proto.g0a", 4'b0000, 4'b0001, 1'b0);
        step("proto.g0b", 4'b0000, 4'b0001, 1'b0);
        check("proto.done0", done, 4'b0001);
        step("proto.g1a", 4'b0000, 4'b0010, 1'b0);
        step("proto.g1b", 4'b0000, 4'b0010, 1'b0);
        check("proto.done1", done, 4'b0010);

        // Starvation on client 3
        step("starve.push", 4'b1000, 4'b0000, 1'b0);
        for (int k = 0; k < STARVE_LIMIT - 1; k++) step("starve.wait", 4'b0000, 4'b0000, 1'b0);
        check("starve.not_yet", starve, 4'b0000);
        step("starve.limit", 4'b0000, 4'b0000, 1'b0);
        check("starve.set", starve, 4'b1000);
        for (int k = 0; k < 3; k++) step("starve.hold", 4'b0000, 4'b0000, 1'b0);
        check("starve.held", starve, 4'b1000);
        step("starve.clr", 4'b0000, 4'b0000, 1'b1);
        check("starve.cleared", starve, 4'b0000);
        step("starve.g3a", 4'b0000, 4'b1000, 1'b0);
        step("starve.g3b", 4'b0000, 4'b1000, 1'b0);
        check("starve.done3", done, 4'b1000);

        // Reset in the middle of a job
        step("mid.push", 4'b0001, 4'b0000, 1'b0);
        step("mid.beat0", 4'b0000, 4'b0001, 1'b0);
        pulse_reset("mid.reset");
        for (int k = 0; k < 4; k++) begin
            step("mid.after", 4'b0000, 4'b0000, 1'b0);
            check("mid.no_done", done, 4'b0000);
        end

        // Random traffic against the model
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic [3:0] p;
            logic [3:0] g;
            logic [3:0] mr;
            logic       c;
            int         sel;
            int         start;
            for (int i = 0; i < 4; i++) p[i] = ($urandom_range(0, 5) == 0);
            mr  = model_req();
            sel = $urandom_range(0, 9);
            g   = 4'b0000;
            if (sel <= 5) begin
                start = $urandom_range(0, 3);
                for (int j = 0; j < 4; j++) begin
                    if (g == 4'b0000 && mr[(start + j) % 4]) g = 4'b0001 << ((start + j) % 4);
                end
            end else if (sel == 7) begin
                g = 4'($urandom_range(0, 15));
            end else if (sel == 8) begin
                g = 4'b0001 << $urandom_range(0, 3);
            end
            c = ($urandom_range(0, 29) == 0);
            step("rand", p, g, c);
            if ($urandom_range(0, 249) == 0) pulse_reset("rand.reset");
        end

        push    = 4'b0000;
        gnt     = 4'b0000;
        clr_err = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
